// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter: FSM encoding and sizes.
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_8_decoder_3x8.sv
// 3-to-8 one-hot decoder with enable; a is the MSB of the select, c the LSB.
module decoder_3x8 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       en,
    output logic [7:0] d
);

    always_comb begin
        d = 8'h00;
        if (en) begin
            d = 8'h01 << {a, b, c};
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a registered, held grant.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be within 1..255");
    end

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [ID_W-1:0]      off;
        logic                 found;
        dbl   = {r, r} >> p;
        rot   = dbl[NUM_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                off   = ID_W'(i);
                found = 1'b1;
            end
        end
        return off + p;
    endfunction

    state_t          state, state_d;
    logic [ID_W-1:0] ptr, ptr_d;
    logic [ID_W-1:0] id_d;
    logic            owner_release;

    assign owner_release = done || !req[gnt_id];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_d;
    logic       timeout_d;
`endif

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        id_d    = gnt_id;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d    = hold_cnt;
        timeout_d = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (en && (req != '0)) begin
                    id_d    = rr_pick(req, ptr);
                    state_d = ST_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (owner_release) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_id + 3'd1;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    ptr_d     = gnt_id + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_cnt + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            gnt_id <= id_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_d;
            timeout  <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = (state == ST_GRANT);

    decoder_3x8 u_decoder (
        .a  (gnt_id[2]),
        .b  (gnt_id[1]),
        .c  (gnt_id[0]),
        .en (gnt_valid),
        .d  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vector table, hand sequences, random vs. reference model.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset, en, done;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner is -1 when idle; held is the number of cycles the grant has lasted.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    task automatic model_step(input logic r, input logic e, input logic [7:0] q, input logic d);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (e && q != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                m_held = 1;
            end
        end else if (d || !q[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            if (m_held == MH) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
`endif
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] q, input logic d);
        reset = r;
        en    = e;
        req   = q;
        done  = d;
        @(posedge clk);
        #1;
        model_step(r, e, q, d);
    endtask

    task automatic check_idle(input string name);
        check({name, "_gnt"}, 32'(gnt), 32'h00);
        check({name, "_valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic check_owner(input string name, input int id);
        check({name, "_gnt"}, 32'(gnt), 32'(8'h01 << id));
        check({name, "_id"}, 32'(gnt_id), 32'(id));
        check({name, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic       valid;
        logic [2:0] id;
    } vec_t;

    vec_t tbl[23];
    logic [7:0] rq;

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        req   = 8'hFF;
        done  = 1'b0;

        tbl = '{
            '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0},  // reset, requests ignored
            '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 3'd0},  // first grant is id 0
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h02, 1'b1, 3'd1},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 3'd5},  // single request
            '{1'b0, 1'b1, 8'h20, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 3'd0},  // en=0 blocks
            '{1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 3'd2},
            '{1'b0, 1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 3'd2},  // en=0 keeps held grant
            '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0},  // owner drops req
            '{1'b0, 1'b1, 8'h81, 1'b0, 8'h80, 1'b1, 3'd7},  // ptr=3 -> 7 wins
            '{1'b0, 1'b1, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'h81, 1'b0, 8'h01, 1'b1, 3'd0},  // wrap to 0
            '{1'b0, 1'b1, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'h81, 1'b0, 8'h80, 1'b1, 3'd7},  // 0 not served twice
            '{1'b0, 1'b1, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0},
            '{1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 3'd4},
            '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0},  // reset mid-grant
            '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 3'd0},  // ptr back at 0
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0}
        };

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done);
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
            if (tbl[i].valid) check($sformatf("tbl%0d_id", i), 32'(gnt_id), 32'(tbl[i].id));
        end

        // Rotation with all requesters active: ptr is 1 here, so ids run 1..7,0,1.
        for (int n = 0; n < 9; n++) begin
            cycle(1'b0, 1'b1, 8'hFF, 1'b0);
            check_owner($sformatf("rot%0d", n), (1 + n) % 8);
            cycle(1'b0, 1'b1, 8'hFF, 1'b1);
            check_idle($sformatf("rot%0d_gap", n));
        end

        // Long hold with no done.
        cycle(1'b1, 1'b1, 8'h00, 1'b0);
        check_idle("hold_rst");
        for (int n = 0; n < MH; n++) begin
            cycle(1'b0, 1'b1, 8'h0C, 1'b0);
            check_owner($sformatf("hold%0d", n), 2);
            check($sformatf("hold%0d_timeout", n), 32'(timeout), 32'd0);
        end
`ifdef RR_ARB_TIMEOUT_EN
        cycle(1'b0, 1'b1, 8'h0C, 1'b0);
        check_idle("to_release");
        check("to_pulse", 32'(timeout), 32'd1);
        cycle(1'b0, 1'b1, 8'h0C, 1'b0);
        check_owner("to_next", 3);
        check("to_pulse_end", 32'(timeout), 32'd0);
`else
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 1'b1, 8'h0C, 1'b0);
            check_owner($sformatf("hold_more%0d", n), 2);
            check($sformatf("hold_more%0d_timeout", n), 32'(timeout), 32'd0);
        end
`endif

        // Randomized traffic against the reference model.
        cycle(1'b1, 1'b1, 8'h00, 1'b0);
        rq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0), rq,
                  ($urandom_range(0, 3) == 0));
            check("rnd_gnt", 32'(gnt), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
            check("rnd_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("rnd_timeout", 32'(timeout), 32'(m_to));
            if (m_owner >= 0) check("rnd_id", 32'(gnt_id), 32'(m_owner));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
